serial_bus_arbiter: RTL and testbench

- Shares the single serial bus between NUM_MASTERS masterExternal instances.
- Each master sends a serial request frame on its arbSend line. The frame carries the target slave ID.
- The arbiter picks one pending master by round-robin and signals grant, then bus-clear, on that master's arbCont line.
- While a master owns the bus, the arbiter drives the one-hot master-select and the slave-select for the bus mux.

---
 rtl/serial_bus_pkg.sv | 43 ++++
 rtl/arb_req_rx.sv | 92 +++++++++
 rtl/serial_bus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_serial_bus_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_bus_pkg.sv
// Shared types, constants and the round-robin pick helper for serial_bus_arbiter
// and its per-master request receivers.
package serial_bus_pkg;

    localparam int unsigned MAX_MASTERS       = 16;
    localparam int unsigned GRANT_PULSE_LEN   = 2;
    localparam int unsigned RELEASE_PULSE_LEN = 1;

    typedef enum logic [2:0] {
        ArbIdle,
        ArbGrant,
        ArbGap,
        ArbOwn,
        ArbRelease
    } arb_state_t;

    typedef enum logic [1:0] {
        RxIdle,
        RxId,
        RxPend,
        RxWaitLow
    } rx_state_t;

    // First set bit at or after pointer. Bits above the real master count must be
    // zero, which makes the 4-bit wrap equivalent to wrapping modulo that count.
    function automatic logic [3:0] rr_pick(input logic [MAX_MASTERS-1:0] pending,
                                           input logic [3:0]             pointer);
        logic [3:0] pick;
        logic [3:0] idx;
        logic       found;
        pick  = pointer;
        found = 1'b0;
        for (int k = 0; k < int'(MAX_MASTERS); k++) begin
            idx = pointer + 4'(k);
            if (!found && pending[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/arb_req_rx.sv
// Per-master serial request receiver: start bit, MSB-first slave ID, then a
// pending flag held until the arbiter releases this master.
module arb_req_rx
    import serial_bus_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 3,
    parameter int unsigned S_ID_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arb_send_i,
    input  logic              release_i,
    output logic              pending_o,
    output logic [S_ID_W-1:0] id_o,
    output logic              bad_o
);

    localparam int unsigned BIT_W = (S_ID_W > 1) ? $clog2(S_ID_W) : 1;

    rx_state_t         state_q, state_d;
    logic [S_ID_W-1:0] shift_q, shift_d;
    logic [S_ID_W-1:0] id_q, id_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              pending_q, pending_d;
    logic [S_ID_W-1:0] frame_id;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        id_d      = id_q;
        bit_cnt_d = bit_cnt_q;
        pending_d = pending_q;
        bad_o     = 1'b0;
        frame_id  = (shift_q << 1) | S_ID_W'(arb_send_i);
        unique case (state_q)
            RxIdle: begin
                if (arb_send_i) begin
                    state_d   = RxId;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            RxId: begin
                shift_d   = frame_id;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BIT_W'(S_ID_W - 1)) begin
                    if (32'(frame_id) < NUM_SLAVES) begin
                        pending_d = 1'b1;
                        id_d      = frame_id;
                        state_d   = RxPend;
                    end else begin
                        bad_o   = 1'b1;
                        state_d = RxWaitLow;
                    end
                end
            end
            // arbSend is ignored while pending or owning; only the arbiter ends this state.
            RxPend: begin
                if (release_i) begin
                    pending_d = 1'b0;
                    state_d   = RxWaitLow;
                end
            end
            RxWaitLow: begin
                if (!arb_send_i) begin
                    state_d = RxIdle;
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RxIdle;
            shift_q   <= '0;
            id_q      <= '0;
            bit_cnt_q <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            id_q      <= id_d;
            bit_cnt_q <= bit_cnt_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;
    assign id_o      = id_q;

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter for the shared serial bus: grant pulse, gap, then bus-clear
// on arbCont, with registered master/slave selects. ARB_TIMEOUT_EN adds a forced
// release after TIMEOUT ownership cycles and a timeoutFlag output.
module serial_bus_arbiter
    import serial_bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned NUM_SLAVES  = 3,
    parameter int unsigned S_ID_W      = 2,
    parameter int unsigned GRANT_GAP   = 3
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT     = 1024
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] arbSend,
    output logic [NUM_MASTERS-1:0] arbCont,
    output logic [NUM_MASTERS-1:0] mSel,
    output logic [S_ID_W-1:0]      sSel,
    output logic                   busBusy,
    output logic                   badReq
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                   timeoutFlag
`endif
);

    localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned CNT_W = $clog2(GRANT_GAP + GRANT_PULSE_LEN + 1);

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] arb_cont_q, arb_cont_d;
    logic [NUM_MASTERS-1:0] m_sel_q, m_sel_d;
    logic [S_ID_W-1:0]      s_sel_q, s_sel_d;
    logic                   bus_busy_q, bus_busy_d;
    logic                   bad_req_q, bad_req_d;
    logic [NUM_MASTERS-1:0] pending, rx_release, rx_bad, owner_oh;
    logic [S_ID_W-1:0]      rx_id [NUM_MASTERS];
    logic [MAX_MASTERS-1:0] pend_ext;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;
`endif

    for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_rx
        arb_req_rx #(
            .NUM_SLAVES(NUM_SLAVES),
            .S_ID_W    (S_ID_W)
        ) u_rx (
            .clk       (clk),
            .rst       (rst),
            .arb_send_i(arbSend[m]),
            .release_i (rx_release[m]),
            .pending_o (pending[m]),
            .id_o      (rx_id[m]),
            .bad_o     (rx_bad[m])
        );
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        rx_release = '0;
        pend_ext   = '0;
        pend_ext[NUM_MASTERS-1:0] = pending;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        timeout_d  = 1'b0;
`endif
        unique case (state_q)
            ArbIdle: begin
                if (|pending) begin
                    owner_d = IDX_W'(rr_pick(pend_ext, 4'(rr_ptr_q)));
                    cnt_d   = '0;
                    state_d = ArbGrant;
                end
            end
            ArbGrant: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(GRANT_PULSE_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = ArbGap;
                end
            end
            ArbGap: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(GRANT_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = ArbOwn;
`ifdef ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            ArbOwn: begin
`ifdef ARB_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                if (arbSend[owner_q]) begin
                    cnt_d   = '0;
                    state_d = ArbRelease;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = ArbRelease;
                end
`endif
            end
            ArbRelease: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(RELEASE_PULSE_LEN - 1)) begin
                    rx_release[owner_q] = 1'b1;
                    rr_ptr_d = (owner_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
                    cnt_d    = '0;
                    state_d  = ArbIdle;
                end
            end
            default: state_d = ArbIdle;
        endcase

        // Outputs follow the next state so they change on the same edge as the FSM.
        owner_oh          = '0;
        owner_oh[owner_d] = 1'b1;
        bus_busy_d = (state_d == ArbGrant) || (state_d == ArbGap) || (state_d == ArbOwn);
        arb_cont_d = ((state_d == ArbGrant) || (state_d == ArbOwn)) ? owner_oh : '0;
        m_sel_d    = bus_busy_d ? owner_oh : '0;
        s_sel_d    = bus_busy_d ? rx_id[owner_d] : '0;
        bad_req_d  = |rx_bad;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ArbIdle;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            arb_cont_q <= '0;
            m_sel_q    <= '0;
            s_sel_q    <= '0;
            bus_busy_q <= 1'b0;
            bad_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            arb_cont_q <= arb_cont_d;
            m_sel_q    <= m_sel_d;
            s_sel_q    <= s_sel_d;
            bus_busy_q <= bus_busy_d;
            bad_req_q  <= bad_req_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeoutFlag = timeout_q;
`endif

    assign arbCont = arb_cont_q;
    assign mSel    = m_sel_q;
    assign sSel    = s_sel_q;
    assign busBusy = bus_busy_q;
    assign badReq  = bad_req_q;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Scoreboard bench for serial_bus_arbiter: stimulus queues expected grants, a
// negedge monitor pops and checks them along with the arbCont grant pattern.
module tb_serial_bus_arbiter;

    typedef struct packed {
        logic [1:0] m;
        logic [1:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   bad_cycles = 0;
    int   exp_bad_cycles = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] arbSend;
    logic [1:0] arbCont;
    logic [1:0] mSel;
    logic [1:0] sSel;
    logic       busBusy;
    logic       badReq;
`ifdef ARB_TIMEOUT_EN
    logic       timeoutFlag;
`endif

    always #5 clk = ~clk;

    serial_bus_arbiter #(
        .NUM_MASTERS(2),
        .NUM_SLAVES (3),
        .S_ID_W     (2),
        .GRANT_GAP  (3)
`ifdef ARB_TIMEOUT_EN
        ,
        .TIMEOUT    (16)
`endif
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .arbSend(arbSend),
        .arbCont(arbCont),
        .mSel   (mSel),
        .sSel   (sSel),
        .busBusy(busBusy),
        .badReq (badReq)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeoutFlag(timeoutFlag)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_grant(input logic [1:0] m, input logic [1:0] id);
        exp_t e;
        e.m  = m;
        e.id = id;
        exp_q.push_back(e);
    endtask

    // Start bit then MSB-first ID on every master in mask, then drop the lines.
    task automatic send_frames(input logic [1:0] mask, input logic [1:0] id0,
                               input logic [1:0] id1);
        logic [2:0] f0;
        logic [2:0] f1;
        f0 = {1'b1, id0};
        f1 = {1'b1, id1};
        for (int b = 2; b >= 0; b--) begin
            @(posedge clk);
            #1;
            arbSend[0] = mask[0] & f0[b];
            arbSend[1] = mask[1] & f1[b];
        end
        @(posedge clk);
        #1;
        arbSend = '0;
    endtask

    task automatic send_frame(input int m, input logic [1:0] id);
        if (m == 0) send_frames(2'b01, id, 2'b00);
        else        send_frames(2'b10, 2'b00, id);
    endtask

    task automatic drive_bits(input int m, input logic [7:0] bits, input int n);
        for (int b = n - 1; b >= 0; b--) begin
            @(posedge clk);
            #1;
            arbSend[m] = bits[b];
        end
        @(posedge clk);
        #1;
        arbSend[m] = 1'b0;
    endtask

    // Returns one tick after the edge that enters OWN (grant 2 + gap 3 after mSel rises).
    task automatic wait_owned(input int m);
        int n;
        n = 0;
        while (!mSel[m] && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("grant_wait_m%0d", m), 32'(mSel[m]), 32'd1);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic release_bus(input int m);
        arbSend[m] = 1'b1;
        @(posedge clk);
        #1;
        arbSend[m] = 1'b0;
        check("release_cont", 32'(arbCont), 32'd0);
        check("release_busy", 32'(busBusy), 32'd0);
    endtask

    initial begin : monitor
        logic       busy_prev;
        int         pat;
        logic [1:0] oh;
        exp_t       e;
        busy_prev = 1'b0;
        pat = 6;
        oh = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_prev = 1'b0;
                pat = 6;
                continue;
            end
            if (badReq) bad_cycles++;
            check("onehot", {30'd0, $onehot0(arbCont), $onehot0(mSel)}, 32'd3);
            if (busBusy && !busy_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant: mSel=%b sSel=%0d, none expected", mSel, sSel);
                    pat = 6;
                end else begin
                    e = exp_q.pop_front();
                    oh = 2'b01 << e.m;
                    check("grant_mSel", 32'(mSel), 32'(oh));
                    check("grant_sSel", 32'(sSel), 32'(e.id));
                    pat = 0;
                end
            end
            if (pat < 6) begin
                check($sformatf("cont_pattern_%0d", pat), 32'(arbCont),
                      (pat < 2 || pat == 5) ? 32'(oh) : 32'd0);
                pat++;
            end
            if (!busBusy && busy_prev) begin
                check("free_outputs", {26'd0, arbCont, mSel, sSel}, 32'd0);
            end
            busy_prev = busBusy;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: run did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b1;
        arbSend = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_cont", 32'(arbCont), 32'd0);
        check("reset_msel", 32'(mSel), 32'd0);
        check("reset_ssel", 32'(sSel), 32'd0);
        check("reset_busy", 32'(busBusy), 32'd0);
        check("reset_bad", 32'(badReq), 32'd0);
        rst = 1'b0;

        repeat (50) begin
            @(posedge clk);
            #1;
            check("idle", {27'd0, arbCont, mSel, busBusy}, 32'd0);
        end

        // Single request, M0 id=2.
        expect_grant(2'd0, 2'd2);
        send_frame(0, 2'd2);
        @(posedge clk);
        #1;
        check("grant_latency_m0", 32'(arbCont), 32'd1);
        wait_owned(0);
        check("own_ssel", 32'(sSel), 32'd2);
        release_bus(0);

        // Bad ID on M1, held high so the receiver must see a low before the next frame.
        exp_bad_cycles += 1;
        drive_bits(1, 8'b0011_1111, 6);
        check("bad_no_grant", 32'(busBusy), 32'd0);
        expect_grant(2'd1, 2'd0);
        send_frame(1, 2'd0);
        @(posedge clk);
        #1;
        check("grant_latency_m1", 32'(arbCont), 32'd2);
        wait_owned(1);
        release_bus(1);

        // Simultaneous frames with pointer back at 0.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_grant(2'd0, 2'd1);
        expect_grant(2'd1, 2'd2);
        send_frames(2'b11, 2'd1, 2'd2);
        wait_owned(0);
        release_bus(0);
        wait_owned(1);
        check("second_ssel", 32'(sSel), 32'd2);
        release_bus(1);

        // Fairness: each master re-requests right after its release.
        repeat (2) @(posedge clk);
        expect_grant(2'd0, 2'd0);
        expect_grant(2'd1, 2'd1);
        send_frames(2'b11, 2'd0, 2'd1);
        for (int r = 0; r < 4; r++) begin
            wait_owned(r % 2);
            release_bus(r % 2);
            if (r < 2) begin
                repeat (2) @(posedge clk);
                expect_grant(2'(r % 2), 2'(r % 2));
                send_frame(r % 2, 2'(r % 2));
            end
        end

        // Reset during ownership drops everything asynchronously.
        repeat (2) @(posedge clk);
        expect_grant(2'd0, 2'd1);
        send_frame(0, 2'd1);
        wait_owned(0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_cont", 32'(arbCont), 32'd0);
        check("midrst_msel", 32'(mSel), 32'd0);
        check("midrst_ssel", 32'(sSel), 32'd0);
        check("midrst_busy", 32'(busBusy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_grant(2'd1, 2'd2);
        send_frame(1, 2'd2);
        @(posedge clk);
        #1;
        check("grant_after_rst", 32'(arbCont), 32'd2);
        wait_owned(1);
        release_bus(1);

`ifdef ARB_TIMEOUT_EN
        repeat (2) @(posedge clk);
        expect_grant(2'd0, 2'd1);
        send_frame(0, 2'd1);
        wait_owned(0);
        repeat (15) @(posedge clk);
        #1;
        check("tmo_not_yet", {30'd0, timeoutFlag, busBusy}, 32'd1);
        @(posedge clk);
        #1;
        check("tmo_fire", {30'd0, timeoutFlag, busBusy}, 32'd2);
        @(posedge clk);
        #1;
        check("tmo_pulse_end", 32'(timeoutFlag), 32'd0);
`endif

        repeat (5) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("bad_cycles", 32'(bad_cycles), 32'(exp_bad_cycles));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
